// File: rtl/tsu_q_regs_if.sv
// Register bus between a host and the time-stamp queue front end.
interface tsu_q_regs_if;
    logic        wr_in;
    logic        rd_in;
    logic [7:0]  addr_in;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (output wr_in, rd_in, addr_in, data_in, input data_out);
    modport slave  (input wr_in, rd_in, addr_in, data_in, output data_out);
endinterface

// File: rtl/tsu_q_regs.sv
// Multi-channel register front end for the time-stamp FIFOs: per-channel pop
// FSM with atomic shadow, auto-pop, threshold/underrun W1C interrupts.
//
// state | meaning
// IDLE  | waiting for a pop command or an auto-pop opportunity
// POP   | q_rd_en_out[c] high for one clock
// WAIT  | FIFO word presented this clock, captured into the shadow
module tsu_q_regs #(
    parameter int N_CH  = 2,
    parameter int TS_W  = 56,
    parameter int LVL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    tsu_q_regs_if.slave           bus,
    input  logic [N_CH*LVL_W-1:0] q_level_in,
    input  logic [N_CH*TS_W-1:0]  q_data_in,
    output logic [N_CH-1:0]       q_rd_en_out,
    output logic [N_CH-1:0]       q_rst_out,
    output logic                  irq_out
);
    typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;

    localparam logic [7:0]  CH_MASK  = 8'((9'd1 << N_CH) - 9'd1);
    localparam logic [15:0] IRQ_MASK = {CH_MASK, CH_MASK};

    logic [1:0]  win_reg;
    logic [2:0]  win_ch;
    logic        win_hit;
    logic        sel_stat;
    logic        sel_en;
    logic [15:0] irq_stat;
    logic [15:0] irq_en;
    logic [15:0] irq_set;
    logic [15:0] irq_w1c;
    logic [N_CH-1:0] thr_set;
    logic [N_CH-1:0] udr_set;
    logic [31:0] ch_rd [N_CH];
    logic [31:0] rd_data;
    logic [31:0] data_q;
    logic        unused_bits;

    assign win_hit  = !bus.addr_in[7];
    assign win_ch   = bus.addr_in[6:4];
    assign win_reg  = bus.addr_in[3:2];
    assign sel_stat = (bus.addr_in[7:2] == 6'h20);
    assign sel_en   = (bus.addr_in[7:2] == 6'h21);
    assign irq_w1c  = (bus.wr_in && sel_stat) ? bus.data_in[15:0] : 16'h0;
    assign irq_set  = {8'(udr_set), 8'(thr_set)};
    assign unused_bits = ^{bus.data_in[31:16], bus.addr_in[1:0]};

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t            state, state_nx;
        logic [LVL_W-1:0]  level;
        logic [LVL_W-1:0]  thresh_r;
        logic [TS_W-1:0]   shadow;
        logic              sel, wr_ctrl, pop_cmd, qrst_cmd, wr_thr, rd_lo;
        logic              auto_r, valid_r, udr_r, thr_q, thr_cond, q_rst_r;
        logic              udr_event, capture, busy;

        assign level    = q_level_in[c*LVL_W +: LVL_W];
        assign sel      = win_hit && (win_ch == 3'(c));
        assign wr_ctrl  = bus.wr_in && sel && (win_reg == 2'd0);
        assign pop_cmd  = wr_ctrl && bus.data_in[0];
        assign qrst_cmd = wr_ctrl && bus.data_in[1];
        assign wr_thr   = bus.wr_in && sel && (win_reg == 2'd3);
        assign rd_lo    = bus.rd_in && sel && (win_reg == 2'd2);
        assign busy     = (state != IDLE);
        assign capture  = (state == WAIT) && !qrst_cmd;
        assign thr_cond = (thresh_r != '0) && (level >= thresh_r);

        assign q_rd_en_out[c] = (state == POP);
        assign q_rst_out[c]   = q_rst_r;
        assign thr_set[c]     = thr_cond && !thr_q;
        assign udr_set[c]     = udr_event;

        // Next state; a queue reset overrides everything, including a pop in the same write
        always_comb begin
            state_nx  = state;
            udr_event = 1'b0;
            if (qrst_cmd) begin
                state_nx = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop_cmd || (auto_r && !valid_r)) begin
                            if (level != '0) state_nx = POP;
                            else if (pop_cmd) udr_event = 1'b1;
                        end
                    end
                    POP:     state_nx = WAIT;
                    WAIT:    state_nx = IDLE;
                    default: state_nx = IDLE;
                endcase
            end
        end

        // FSM state register
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) state <= IDLE;
            else      state <= state_nx;
        end

        // Channel control/status, shadow capture and threshold edge detect
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                auto_r   <= 1'b0;
                valid_r  <= 1'b0;
                udr_r    <= 1'b0;
                thresh_r <= '0;
                shadow   <= '0;
                thr_q    <= 1'b0;
                q_rst_r  <= 1'b0;
            end else begin
                q_rst_r <= qrst_cmd;
                thr_q   <= thr_cond;
                if (wr_ctrl) auto_r <= bus.data_in[2];
                if (wr_thr)  thresh_r <= bus.data_in[LVL_W-1:0];
                if (capture) shadow <= q_data_in[c*TS_W +: TS_W];
                // capture beats a same-edge DATA_LO read
                if (qrst_cmd)     valid_r <= 1'b0;
                else if (capture) valid_r <= 1'b1;
                else if (rd_lo)   valid_r <= 1'b0;
                if (qrst_cmd)            udr_r <= 1'b0;
                else if (udr_event)      udr_r <= 1'b1;
                else if (irq_w1c[8 + c]) udr_r <= 1'b0;
            end
        end

        always_comb begin
            ch_rd[c] = 32'h0;
            case (win_reg)
                2'd0: ch_rd[c] = {16'(level), 12'h0, udr_r, auto_r, busy, valid_r};
                2'd1: ch_rd[c] = 32'(shadow >> 32);
                2'd2: ch_rd[c] = shadow[31:0];
                2'd3: ch_rd[c] = 32'(thresh_r);
                default: ch_rd[c] = 32'h0;
            endcase
        end
    end

    // Read mux; unmapped and absent-channel addresses return 0
    always_comb begin
        rd_data = 32'h0;
        for (int c = 0; c < N_CH; c++) begin
            if (win_hit && (win_ch == 3'(c))) rd_data = ch_rd[c];
        end
        if (sel_stat) rd_data = {16'h0, irq_stat};
        if (sel_en)   rd_data = {16'h0, irq_en};
    end

    // Interrupt status (set wins over W1C), enable, and registered request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_stat <= 16'h0;
            irq_en   <= 16'h0;
            irq_out  <= 1'b0;
        end else begin
            irq_stat <= ((irq_stat & ~irq_w1c) | irq_set) & IRQ_MASK;
            if (bus.wr_in && sel_en) irq_en <= bus.data_in[15:0] & IRQ_MASK;
            irq_out <= |(irq_stat & irq_en);
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          data_q <= 32'h0;
        else if (bus.rd_in) data_q <= rd_data;
    end

    assign bus.data_out = data_q;
endmodule
